// File: rtl/fractal_pixel_engine.sv
// fractal_pixel_engine
// Escape-time Mandelbrot/Julia generator in signed fixed point. Emits one
// {8'h00, R, G, B} pixel per AXI4-Stream beat in raster order. The complex
// plane is walked with adders, and the pixel position advances only on a
// completed stream handshake.
module fractal_pixel_engine #(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 8,
    parameter int ITER_W    = 8,
    parameter int G_MUL     = 3,
    parameter int B_MUL     = 5
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     frame_enable,
    input  logic                     cfg_mode,
    input  logic signed [DATA_W-1:0] cfg_c_re,
    input  logic signed [DATA_W-1:0] cfg_c_im,
    input  logic signed [DATA_W-1:0] cfg_offset_re,
    input  logic signed [DATA_W-1:0] cfg_offset_im,
    input  logic signed [DATA_W-1:0] cfg_step_re,
    input  logic signed [DATA_W-1:0] cfg_step_im,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    output logic [31:0]              out_stream_tdata,
    output logic [3:0]               out_stream_tkeep,
    output logic                     out_stream_tvalid,
    input  logic                     out_stream_tready,
    output logic                     out_stream_tlast,
    output logic                     out_stream_tuser,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int PW = 2 * DATA_W;

    // Escape radius squared (4.0) at DATA_W+1 bits so the magnitude sum cannot wrap.
    localparam logic signed [DATA_W:0] C_ESCAPE = (DATA_W+1)'(longint'(4) << FRAC_BITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Reset synchroniser
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // Shadow configuration
    logic                     r_cfg_mode;
    logic signed [DATA_W-1:0] r_cfg_c_re;
    logic signed [DATA_W-1:0] r_cfg_c_im;
    logic signed [DATA_W-1:0] r_cfg_off_re;
    logic signed [DATA_W-1:0] r_cfg_off_im;
    logic signed [DATA_W-1:0] r_cfg_step_re;
    logic signed [DATA_W-1:0] r_cfg_step_im;
    logic [ITER_W-1:0]        r_cfg_max_iter;

    // Pixel position and plane point
    logic [XW-1:0]            r_x;
    logic [YW-1:0]            r_y;
    logic signed [DATA_W-1:0] r_p_re;
    logic signed [DATA_W-1:0] r_p_im;

    // Iteration state
    logic signed [DATA_W-1:0] r_zr;
    logic signed [DATA_W-1:0] r_zi;
    logic signed [DATA_W-1:0] r_c_re;
    logic signed [DATA_W-1:0] r_c_im;
    logic [ITER_W-1:0]        r_iter;

    logic                     r_frame_done;

    // Datapath wires
    logic signed [DATA_W-1:0] w_zr2;
    logic signed [DATA_W-1:0] w_zi2;
    logic signed [DATA_W-1:0] w_zri;
    logic signed [DATA_W:0]   w_mag;
    logic                     w_escape;
    logic                     w_iter_stop;
    logic                     w_handshake;
    logic                     w_x_last;
    logic                     w_y_last;
    logic                     w_frame_last;
    logic                     w_load_cfg;
    logic [31:0]              w_iter_ext;
    logic [7:0]               w_red;
    logic [7:0]               w_green;
    logic [7:0]               w_blue;
    logic                     w_black;

    // Asynchronous assertion, release synchronised to aclk
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Fixed-point square and cross products: full-width multiply, floor shift, truncate
    assign w_zr2 = DATA_W'(((PW)'(r_zr) * (PW)'(r_zr)) >>> FRAC_BITS);
    assign w_zi2 = DATA_W'(((PW)'(r_zi) * (PW)'(r_zi)) >>> FRAC_BITS);
    assign w_zri = DATA_W'(((PW)'(r_zr) * (PW)'(r_zi)) >>> (FRAC_BITS - 1));

    assign w_mag       = (DATA_W+1)'(w_zr2) + (DATA_W+1)'(w_zi2);
    assign w_escape    = (w_mag > C_ESCAPE);
    assign w_iter_stop = w_escape || (r_iter == r_cfg_max_iter);

    assign w_handshake  = (r_state == S_OUT) && out_stream_tready;
    assign w_x_last     = (r_x == XW'(X_SIZE - 1));
    assign w_y_last     = (r_y == YW'(Y_SIZE - 1));
    assign w_frame_last = w_handshake && w_x_last && w_y_last;
    assign w_load_cfg   = frame_enable && ((r_state == S_IDLE) || w_frame_last);

    // State register
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_enable) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_state_next = S_ITER;
            end
            S_ITER: begin
                if (w_iter_stop) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (w_handshake) begin
                    if (w_x_last && w_y_last && !frame_enable) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_INIT;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Shadow configuration, captured at frame start only
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cfg_mode     <= 1'b0;
            r_cfg_c_re     <= '0;
            r_cfg_c_im     <= '0;
            r_cfg_off_re   <= '0;
            r_cfg_off_im   <= '0;
            r_cfg_step_re  <= '0;
            r_cfg_step_im  <= '0;
            r_cfg_max_iter <= '0;
        end else if (w_load_cfg) begin
            r_cfg_mode     <= cfg_mode;
            r_cfg_c_re     <= cfg_c_re;
            r_cfg_c_im     <= cfg_c_im;
            r_cfg_off_re   <= cfg_offset_re;
            r_cfg_off_im   <= cfg_offset_im;
            r_cfg_step_re  <= cfg_step_re;
            r_cfg_step_im  <= cfg_step_im;
            r_cfg_max_iter <= cfg_max_iter;
        end
    end

    // Raster position and plane point, advanced on each accepted beat
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_p_re <= '0;
            r_p_im <= '0;
        end else if (w_load_cfg) begin
            // New frame: the shadow offset is being loaded this cycle, so take it from the port
            r_x    <= '0;
            r_y    <= '0;
            r_p_re <= cfg_offset_re;
            r_p_im <= cfg_offset_im;
        end else if (w_handshake) begin
            if (!w_x_last) begin
                r_x    <= r_x + XW'(1);
                r_p_re <= r_p_re + r_cfg_step_re;
            end else begin
                r_x    <= '0;
                r_p_re <= r_cfg_off_re;
                if (!w_y_last) begin
                    r_y    <= r_y + YW'(1);
                    r_p_im <= r_p_im + r_cfg_step_im;
                end else begin
                    r_y    <= '0;
                    r_p_im <= r_cfg_off_im;
                end
            end
        end
    end

    // Per-pixel seed and z <- z^2 + c iteration
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_zr   <= '0;
            r_zi   <= '0;
            r_c_re <= '0;
            r_c_im <= '0;
            r_iter <= '0;
        end else if (r_state == S_INIT) begin
            if (r_cfg_mode) begin
                r_zr   <= r_p_re;
                r_zi   <= r_p_im;
                r_c_re <= r_cfg_c_re;
                r_c_im <= r_cfg_c_im;
            end else begin
                r_zr   <= '0;
                r_zi   <= '0;
                r_c_re <= r_p_re;
                r_c_im <= r_p_im;
            end
            r_iter <= '0;
        end else if ((r_state == S_ITER) && !w_iter_stop) begin
            r_zr   <= w_zr2 - w_zi2 + r_c_re;
            r_zi   <= w_zri + r_c_im;
            r_iter <= r_iter + ITER_W'(1);
        end
    end

    // One-cycle pulse after the final beat of a frame is accepted
    always_ff @(posedge aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_last;
        end
    end

    // Colour map; r_iter is frozen in OUT so tdata is stable under backpressure
    assign w_iter_ext = 32'(r_iter);
    assign w_black    = (r_iter == r_cfg_max_iter);
    assign w_red      = 8'(w_iter_ext);
    assign w_green    = 8'(w_iter_ext * 32'(G_MUL));
    assign w_blue     = 8'(w_iter_ext * 32'(B_MUL));

    assign out_stream_tvalid = (r_state == S_OUT);
    assign out_stream_tdata  = (out_stream_tvalid && !w_black) ? {8'h00, w_red, w_green, w_blue} : '0;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = out_stream_tvalid && w_x_last;
    assign out_stream_tuser  = out_stream_tvalid && (r_x == '0) && (r_y == '0);
    assign busy              = (r_state != S_IDLE);
    assign frame_done        = r_frame_done;

endmodule

// File: tb/tb_fractal_pixel_engine.sv
// tb_fractal_pixel_engine
// Self-checking bench: table of known 4x2 Mandelbrot beats, a 1x1 Julia
// instance, backpressure, mid-frame config changes, resets, and random frames
// checked against an arithmetic escape-time model.
module tb_fractal_pixel_engine;

    localparam int AX = 4;
    localparam int AY = 2;
    localparam int NB = AX * AY;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
        int unsigned c;
    } beat_t;

    typedef struct {
        int          x;
        int          y;
        logic [31:0] d;
        logic        l;
        logic        u;
    } vec_t;

    logic clk = 1'b0;
    logic aresetn;

    // DUT A (4x2) stimulus/observation
    logic               en_a;
    logic               mode_a;
    logic signed [31:0] cre_a, cim_a, ore_a, oim_a, sre_a, sim_a;
    logic [7:0]         max_a;
    logic [31:0]        tdata_a;
    logic [3:0]         tkeep_a;
    logic               tvalid_a, tready_a, tlast_a, tuser_a, busy_a, fd_a;

    // DUT J (1x1 Julia)
    logic               en_j;
    logic [31:0]        tdata_j;
    logic [3:0]         tkeep_j;
    logic               tvalid_j, tlast_j, tuser_j, busy_j, fd_j;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned stall_cnt = 0;
    int          ready_mode = 0;

    beat_t       qa[$];
    beat_t       qj[$];
    int unsigned fdq[$];
    beat_t       ref_b[NB];
    vec_t        tbl[NB];
    logic [31:0] exp_d[NB];
    logic        exp_l[NB];
    logic        exp_u[NB];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l, prev_u;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    fractal_pixel_engine #(
        .X_SIZE(AX),
        .Y_SIZE(AY)
    ) dut (
        .aclk              (clk),
        .aresetn           (aresetn),
        .frame_enable      (en_a),
        .cfg_mode          (mode_a),
        .cfg_c_re          (cre_a),
        .cfg_c_im          (cim_a),
        .cfg_offset_re     (ore_a),
        .cfg_offset_im     (oim_a),
        .cfg_step_re       (sre_a),
        .cfg_step_im       (sim_a),
        .cfg_max_iter      (max_a),
        .out_stream_tdata  (tdata_a),
        .out_stream_tkeep  (tkeep_a),
        .out_stream_tvalid (tvalid_a),
        .out_stream_tready (tready_a),
        .out_stream_tlast  (tlast_a),
        .out_stream_tuser  (tuser_a),
        .busy              (busy_a),
        .frame_done        (fd_a)
    );

    fractal_pixel_engine #(
        .X_SIZE(1),
        .Y_SIZE(1)
    ) dut_j (
        .aclk              (clk),
        .aresetn           (aresetn),
        .frame_enable      (en_j),
        .cfg_mode          (1'b1),
        .cfg_c_re          (32'sd0),
        .cfg_c_im          (32'sd0),
        .cfg_offset_re     (32'sd384),
        .cfg_offset_im     (32'sd0),
        .cfg_step_re       (32'sd0),
        .cfg_step_im       (32'sd0),
        .cfg_max_iter      (8'd20),
        .out_stream_tdata  (tdata_j),
        .out_stream_tkeep  (tkeep_j),
        .out_stream_tvalid (tvalid_j),
        .out_stream_tready (1'b1),
        .out_stream_tlast  (tlast_j),
        .out_stream_tuser  (tuser_j),
        .busy              (busy_j),
        .frame_done        (fd_j)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference escape-time count from plain integer arithmetic
    function automatic int unsigned model_iter(input bit mode, input int pre, input int pim,
                                               input int cre, input int cim, input int unsigned mx);
        int zr, zi, kr, ki, zr2, zi2, zri;
        longint mag;
        if (mode) begin
            zr = pre; zi = pim; kr = cre; ki = cim;
        end else begin
            zr = 0; zi = 0; kr = pre; ki = pim;
        end
        for (int unsigned it = 0; it < 300; it++) begin
            zr2 = int'((longint'(zr) * longint'(zr)) >>> 8);
            zi2 = int'((longint'(zi) * longint'(zi)) >>> 8);
            zri = int'((longint'(zr) * longint'(zi)) >>> 7);
            mag = longint'(zr2) + longint'(zi2);
            if (mag > 1024 || it == mx) return it;
            zr = zr2 - zi2 + kr;
            zi = zri + ki;
        end
        return 0;
    endfunction

    function automatic logic [31:0] colour(input int unsigned it, input int unsigned mx);
        logic [7:0] r, g, b;
        if (it == mx) return 32'h0;
        r = 8'(it);
        g = 8'(it * 3);
        b = 8'(it * 5);
        return {8'h00, r, g, b};
    endfunction

    task automatic build_exp(input bit mode, input int ore, input int oim, input int sre,
                             input int sim, input int cre, input int cim, input int unsigned mx);
        int unsigned it;
        for (int y = 0; y < AY; y++) begin
            for (int x = 0; x < AX; x++) begin
                it = model_iter(mode, ore + x * sre, oim + y * sim, cre, cim, mx);
                exp_d[y*AX+x] = colour(it, mx);
                exp_l[y*AX+x] = (x == AX - 1);
                exp_u[y*AX+x] = (x == 0 && y == 0);
            end
        end
    endtask

    task automatic load_tbl();
        for (int i = 0; i < NB; i++) begin
            exp_d[i] = tbl[i].d;
            exp_l[i] = tbl[i].l;
            exp_u[i] = tbl[i].u;
        end
    endtask

    task automatic set_cfg(input bit mode, input int ore, input int oim, input int sre,
                           input int sim, input int cre, input int cim, input int unsigned mx);
        mode_a = mode; ore_a = ore; oim_a = oim; sre_a = sre; sim_a = sim;
        cre_a = cre; cim_a = cim; max_a = 8'(mx);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_en();
        @(posedge clk); #1 en_a = 1'b1;
        @(posedge clk); #1 en_a = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k = 0;
        while (qa.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({tag, " beat count"}, qa.size(), n);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!tvalid_a && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({tag, " tvalid reached"}, tvalid_a, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy_a && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({tag, " idle"}, busy_a, 0);
    endtask

    task automatic cmp_frame(input string tag);
        beat_t b;
        for (int i = 0; i < NB; i++) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s beat%0d: got no beat expected 0x%08h", tag, i, exp_d[i]);
            end else begin
                b = qa.pop_front();
                check($sformatf("%s beat%0d data", tag, i), b.d, exp_d[i]);
                check($sformatf("%s beat%0d tlast", tag, i), b.l, exp_l[i]);
                check($sformatf("%s beat%0d tuser", tag, i), b.u, exp_u[i]);
            end
        end
    endtask

    // Sink readiness driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tready_a = 1'b1;
            1: tready_a = 1'($urandom_range(0, 1));
            default: tready_a = 1'b0;
        endcase
    end

    // Beat collector and stall-stability monitor
    always @(negedge clk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_cnt++;
                check("stall tvalid", tvalid_a, 1);
                check("stall tdata", tdata_a, prev_d);
                check("stall tlast", tlast_a, prev_l);
                check("stall tuser", tuser_a, prev_u);
            end
            if (tvalid_a && tready_a) qa.push_back('{tdata_a, tlast_a, tuser_a, cyc});
            if (tvalid_j) qj.push_back('{tdata_j, tlast_j, tuser_j, cyc});
            if (fd_a) fdq.push_back(cyc);
            prev_stall = tvalid_a && !tready_a;
            prev_d = tdata_a;
            prev_l = tlast_a;
            prev_u = tuser_a;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int unsigned mx;
        beat_t bj;

        // Known 4x2 Mandelbrot frame: offset (-2,0), step 1.0, max_iter 20
        tbl[0] = '{0, 0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[1] = '{1, 0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[2] = '{2, 0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3] = '{3, 0, 32'h0003_090F, 1'b1, 1'b0};
        tbl[4] = '{0, 1, 32'h0001_0305, 1'b0, 1'b0};
        tbl[5] = '{1, 1, 32'h0003_090F, 1'b0, 1'b0};
        tbl[6] = '{2, 1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[7] = '{3, 1, 32'h0002_060A, 1'b1, 1'b0};

        aresetn = 1'b0;
        en_a = 1'b0;
        en_j = 1'b0;
        tready_a = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        ready_mode = 1;

        // Reset held: outputs quiet despite toggling inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("reset tvalid", tvalid_a, 0);
            check("reset busy", busy_a, 0);
            check("reset frame_done", fd_a, 0);
            check("reset tkeep", tkeep_a, 4'hF);
            en_a = 1'($urandom_range(0, 1));
            mode_a = 1'($urandom_range(0, 1));
            max_a = 8'($urandom);
        end
        en_a = 1'b0;
        ready_mode = 0;
        @(posedge clk); #1 aresetn = 1'b1;
        tick(6);
        check("post-reset idle busy", busy_a, 0);
        check("post-reset idle tvalid", tvalid_a, 0);

        // Table-driven zero-stall frame
        qa.delete(); fdq.delete();
        set_cfg(0, -512, 0, 256, 256, 0, 0, 20);
        pulse_en();
        wait_beats("mandel", NB, 4000);
        for (int i = 0; i < NB; i++) begin
            if (i < qa.size()) ref_b[i] = qa[i];
        end
        if (qa.size() >= 4) begin
            gap = int'(qa[3].c) - int'(qa[2].c);
            check("pixel(3,0) ITER cycles", 32'(gap - 2), 4);
        end
        load_tbl();
        cmp_frame("mandel");
        tick(3);
        check("mandel frame_done count", fdq.size(), 1);
        if (fdq.size() >= 1) check("mandel frame_done timing", fdq[0], ref_b[NB-1].c + 1);
        check("mandel returns idle", busy_a, 0);

        // Backpressure: 10 stalled cycles then random readiness
        qa.delete();
        stall_cnt = 0;
        ready_mode = 2;
        pulse_en();
        wait_valid("bp", 500);
        tick(10);
        ready_mode = 1;
        wait_beats("bp", NB, 8000);
        for (int i = 0; i < NB; i++) begin
            exp_d[i] = ref_b[i].d;
            exp_l[i] = ref_b[i].l;
            exp_u[i] = ref_b[i].u;
        end
        cmp_frame("bp");
        check("bp stall cycles observed", (stall_cnt >= 10), 1);
        ready_mode = 0;
        wait_idle("bp", 200);

        // Julia 1x1, enable held: every frame produces the same pixel
        qj.delete();
        @(posedge clk); #1 en_j = 1'b1;
        for (int k = 0; k < 200 && qj.size() < 3; k++) tick(1);
        en_j = 1'b0;
        check("julia beat count", (qj.size() >= 3), 1);
        for (int i = 0; i < 3 && qj.size() > 0; i++) begin
            bj = qj.pop_front();
            check($sformatf("julia frame%0d data", i), bj.d, 32'h0001_0305);
            check($sformatf("julia frame%0d tlast", i), bj.l, 1);
            check($sformatf("julia frame%0d tuser", i), bj.u, 1);
            if (i > 0) check($sformatf("julia frame%0d period", i), bj.c - ref_b[0].c, 4);
            ref_b[0] = bj;
        end

        // Mid-frame: new limit and dropped enable apply only to the next frame
        qa.delete(); fdq.delete();
        set_cfg(0, -512, 0, 256, 256, 0, 0, 20);
        @(posedge clk); #1 en_a = 1'b1;
        wait_beats("mid first", 2, 2000);
        max_a = 8'd2;
        en_a = 1'b0;
        wait_beats("mid", NB, 4000);
        load_tbl();
        cmp_frame("mid old");
        tick(3);
        check("mid frame_done count", fdq.size(), 1);
        check("mid returns idle", busy_a, 0);
        check("mid no extra beats", qa.size(), 0);
        build_exp(0, -512, 0, 256, 256, 0, 0, 2);
        pulse_en();
        wait_beats("mid new", NB, 4000);
        cmp_frame("mid new");
        wait_idle("mid new", 200);

        // Randomised frames against the model
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            if (f == 0) mx = 0;
            else if (f == 1) mx = 255;
            else mx = $urandom_range(1, 40);
            set_cfg(1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1280)) - 640, int'($urandom_range(0, 1280)) - 640,
                    int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
                    int'($urandom_range(0, 1024)) - 512, int'($urandom_range(0, 1024)) - 512, mx);
            build_exp(mode_a, ore_a, oim_a, sre_a, sim_a, cre_a, cim_a, mx);
            qa.delete();
            pulse_en();
            wait_beats($sformatf("rand%0d", f), NB, 8000);
            cmp_frame($sformatf("rand%0d", f));
            wait_idle($sformatf("rand%0d", f), 200);
        end

        // Reset while a beat is presented: tvalid drops without a clock edge
        set_cfg(0, -512, 0, 256, 256, 0, 0, 20);
        ready_mode = 2;
        pulse_en();
        wait_valid("rst_out", 500);
        #2 aresetn = 1'b0;
        #1;
        check("rst_out tvalid async", tvalid_a, 0);
        check("rst_out busy async", busy_a, 0);
        tick(2);
        aresetn = 1'b1;
        ready_mode = 0;
        tick(4);

        // Reset during ITER, then a clean frame starting at pixel (0,0)
        qa.delete();
        pulse_en();
        wait_beats("rst_iter first", 1, 2000);
        tick(3);
        check("rst_iter computing busy", busy_a, 1);
        check("rst_iter computing tvalid", tvalid_a, 0);
        #2 aresetn = 1'b0;
        #1;
        check("rst_iter busy async", busy_a, 0);
        tick(2);
        aresetn = 1'b1;
        tick(4);
        qa.delete();
        pulse_en();
        wait_beats("after reset", NB, 4000);
        load_tbl();
        cmp_frame("after reset");
        wait_idle("after reset", 200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fractal_pixel_engine.md
# fractal_pixel_engine

Parametrised fixed-point escape-time fractal generator producing one RGB pixel per AXI4-Stream beat in raster order. Runtime inputs select Mandelbrot or Julia mode and set the complex-plane window and iteration limit. It supersedes the fixed 640x480 Mandelbrot/Julia generator: the plane is walked with adders (no per-pixel divides), and pixel position advances only on a completed stream handshake. It sits between the AXI-Lite register block, which drives the `cfg_*` inputs, and the video DMA / packer path.

## Interface
- `X_SIZE`, 640, pixels per line
- `Y_SIZE`, 480, lines per frame
- `DATA_W`, 32, signed fixed-point word width; must be ≥ FRAC_BITS+6
- `FRAC_BITS`, 8, fractional bits (1.0 = 2^FRAC_BITS)
- `ITER_W`, 8, iteration counter width
- `G_MUL`, 3, green colour multiplier
- `B_MUL`, 5, blue colour multiplier

Ports:
- `aclk`  in  1  single clock for all logic
- `aresetn`  in  1  asynchronous active-low reset
- `frame_enable`  in  1  run frames while high
- `cfg_mode`  in  1  0 = Mandelbrot, 1 = Julia
- `cfg_c_re`, `cfg_c_im`  in  DATA_W  Julia constant
- `cfg_offset_re`, `cfg_offset_im`  in  DATA_W  plane point of pixel (0,0)
- `cfg_step_re`, `cfg_step_im`  in  DATA_W  per-pixel and per-line increments
- `cfg_max_iter`  in  ITER_W  iteration limit
- `out_stream_tdata`  out  32  {8'h00, R, G, B}
- `out_stream_tkeep`  out  4  constant 4'hF
- `out_stream_tvalid`  out  1  pixel valid
- `out_stream_tready`  in  1  sink ready
- `out_stream_tlast`  out  1  last pixel of line (x = X_SIZE-1)
- `out_stream_tuser`  out  1  start of frame (x = 0, y = 0)
- `busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- States: IDLE, INIT, ITER, OUT.
- **IDLE**
  - If `frame_enable`: latch all `cfg_*` into shadow registers.
  - Set x = y = 0, p_re = offset_re, p_im = offset_im; go to INIT.
  - Config changes mid-frame are ignored until the next frame.
- **INIT**
  - Mandelbrot: c = p, z = 0.
  - Julia: z = p, c = shadow c.
  - Set iter = 0; go to ITER.
- **ITER** (one iteration per cycle)
  - zr2 = (zr·zr) >>> FRAC_BITS, zi2 = (zi·zi) >>> FRAC_BITS, zri = (zr·zi) >>> (FRAC_BITS-1).
  - Products are full 2·DATA_W width; arithmetic shift (floor); result truncated to DATA_W.
  - If zr2+zi2 > 4<<FRAC_BITS (compared at DATA_W+1 bits) or iter == max_iter: go to OUT holding iter.
  - Otherwise: zr ← zr2−zi2+c_re, zi ← zri+c_im, iter++.
  - The escape test takes priority over the update; equality with 4.0 does not escape.
- **OUT**
  - tvalid = 1; tdata, tlast and tuser are held stable until tready.
  - Colour: if iter == max_iter, RGB = 0. Otherwise R = iter[7:0], G = (iter·G_MUL)[7:0], B = (iter·B_MUL)[7:0].
  - On handshake:
    - x not last: x++, p_re += step_re.
    - x last, y not last: x = 0, p_re = offset_re, p_im += step_im, y++.
    - Last pixel of frame: pulse `frame_done`. If `frame_enable` is high, relatch config and return to INIT for pixel (0,0); otherwise go to IDLE.
    - Any other pixel: go to INIT.
- Deasserting `frame_enable` mid-frame does not truncate the frame.
- `cfg_max_iter` = 0 makes every pixel output black with zero iterations.
- `busy` is high in INIT, ITER and OUT.

## Timing
- Reset values: all outputs 0 except tkeep = 4'hF; state = IDLE, x = y = 0. Reset takes effect immediately (asynchronous); release is synchronised to `aclk`.
- IDLE→INIT takes 1 cycle after `frame_enable` is sampled high.
- Pixel cycle = 1 (INIT) + (iter+1) (ITER) + ≥1 (OUT).
- Zero-stall throughput: one pixel per iter+3 cycles.
- tvalid never drops without a handshake; tdata never changes while tvalid && !tready.
- `frame_done` is asserted the cycle after the final handshake, for one cycle.
- Reset mid-frame: the pixel in flight is discarded; the first pixel after reset carries tuser = 1.

## Test plan
- Reset: hold aresetn low, toggle inputs → tvalid = busy = frame_done = 0, tkeep = F; after release with frame_enable = 0, state stays IDLE.
- Mandelbrot, X_SIZE = 4, Y_SIZE = 2, offset = (−512, 0), step = (256, 256), max_iter = 20:
  - Row 0 tdata = 0, 0, 0, 0x0003090F.
  - tuser only on beat 0; tlast on beats 3 and 7; frame_done after beat 7.
  - ITER cycles for pixel (3,0) = 4.
- Julia, X_SIZE = Y_SIZE = 1, c = 0, offset = (384, 0), max_iter = 20 → tdata 0x00010305, every frame.
- Backpressure: tready low for 10 cycles during OUT, then random 50% → tdata/tlast/tuser stable while stalled; beat sequence identical to the zero-stall run.
- Mid-frame: change cfg_max_iter and drop frame_enable at pixel 2 → the current frame completes with the old settings, frame_done pulses, state returns to IDLE; re-enable → the next frame uses the new limit.
- Assert aresetn low during ITER → tvalid falls within the same cycle; after release, the first beat is pixel (0,0) with tuser = 1.
